// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 7-10).
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam int unsigned MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   logic [31:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
   logic [3:0]    op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          is_mul, is_div, a_neg, b_neg;
   logic [63:0]   prod_s, prod_u, res;
   logic [31:0]   a_mag, b_mag, divisor, quo_u, rem_u, quo, rem;

   assign busy = cnt_q != '0;
   assign HI   = hi_q;
   assign LO   = lo_q;

   always_comb begin
`ifdef MDU_MADD_EN
      is_mul = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
      is_mul = op inside {OP_MULT, OP_MULTU};
`endif
      is_div = op inside {OP_DIV, OP_DIVU};
   end

   // Sign-extended 64-bit operands make the low 64 product bits the signed product.
   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Signed divide runs on magnitudes; -2^31 / -1 naturally wraps to 0x80000000.
   always_comb begin
      a_neg   = (op_q == OP_DIV) & a_q[31];
      b_neg   = (op_q == OP_DIV) & b_q[31];
      a_mag   = a_neg ? -a_q : a_q;
      b_mag   = b_neg ? -b_q : b_q;
      divisor = b_mag == 32'd0 ? 32'd1 : b_mag;
      quo_u   = a_mag / divisor;
      rem_u   = a_mag % divisor;
      quo     = (a_neg ^ b_neg) ? -quo_u : quo_u;
      rem     = a_neg ? -rem_u : rem_u;
   end

   always_comb begin
      res = {hi_q, lo_q};
      case (op_q)
         OP_MULT:         res = prod_s;
         OP_MULTU:        res = prod_u;
         OP_DIV, OP_DIVU: res = b_q == 32'd0 ? {hi_q, lo_q} : {rem, quo};
`ifdef MDU_MADD_EN
         OP_MADD:         res = {hi_q, lo_q} + prod_s;
         OP_MADDU:        res = {hi_q, lo_q} + prod_u;
         OP_MSUB:         res = {hi_q, lo_q} - prod_s;
         OP_MSUBU:        res = {hi_q, lo_q} - prod_u;
`endif
         default:         res = {hi_q, lo_q};
      endcase
   end

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      cnt_d = cnt_q;
      if (busy) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) {hi_d, lo_d} = res;
      end else if (start) begin
         if (op == OP_MTHI) hi_d = A;
         if (op == OP_MTLO) lo_d = A;
         if (is_mul || is_div) begin
            a_d   = A;
            b_d   = B;
            op_d  = op;
            cnt_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         a_q   <= a_d;
         b_q   <= b_d;
         op_q  <= op_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide unit with HI/LO registers, in the EX stage directly upstream of the EX/MEM pipeline register.
- Executes mult, multu, div, divu, mthi and mtlo over a fixed number of cycles.
- Drives busy so the hazard unit stalls later HI/LO users (mfhi, mflo, mult/div, mthi, mtlo).
- The value selected from HI/LO becomes the EX result latched into EX/MEM.

Parameters:
MULT_CYCLES, 5, cycles busy is held for mult/multu (legal range ≥1)
DIV_CYCLES, 10, cycles busy is held for div/divu (legal range ≥1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
start  input  1  issue strobe; sampled at the rising edge together with op/A/B
op  input  4  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=madd, 8=maddu, 9=msub, 10=msubu (7-10 only with the optional feature)
A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
B  input  32  rt operand (divisor / multiplier)
busy  output  1  high while a multi-cycle op is in flight
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
Reset:
- On reset, asynchronously: HI=0, LO=0, busy=0, cycle counter=0, latched operands/op=0.
- Reset mid-operation aborts the op; no HI/LO write ever occurs for it.

Issue:
- An op is accepted at a rising edge when start=1, busy=0 and op≠0.
- start while busy=1 is ignored entirely: no state change, the in-flight op is unaffected. Upstream must stall.
- start with op=0 or an undefined op code is a no-op.

mthi/mtlo:
- The accepted edge writes A into HI (mthi) or LO (mtlo).
- busy stays 0; the other register is unchanged.
- New value is visible in the cycle after the edge.

Multi-cycle ops:
- The accepted edge latches A, B and op, and loads the counter with N (MULT_CYCLES for mult-class, DIV_CYCLES for div-class).
- busy = (counter≠0), so busy rises in the cycle after the accepted edge and stays high for exactly N cycles.
- Each edge with counter≠0 decrements the counter.
- On the edge where the counter goes 1→0, HI/LO are written and busy falls. Both changes are visible in the same cycle.
- HI/LO hold their old values throughout the busy window.
- A new start may be accepted at the first edge where busy=0, i.e. back-to-back ops carry no bubble beyond N.

Arithmetic:
- mult: {HI,LO} = signed(A)×signed(B), 64-bit.
- multu: {HI,LO} = unsigned(A)×unsigned(B), 64-bit.
- div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- divu: LO = A/B, HI = A%B, unsigned.
- Divide by zero (B=0, div or divu): HI and LO are left unchanged; busy timing is identical to a normal divide.
- div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- The result is computed from the latched operands. Changes on A/B during busy have no effect.

Optional Feature:
Macro: MDU_MADD_EN
- Defined: ops 7-10 are decoded and take MULT_CYCLES.
  - madd: {HI,LO} += signed product.
  - maddu: {HI,LO} += unsigned product.
  - msub: {HI,LO} -= signed product.
  - msubu: {HI,LO} -= unsigned product.
  - Arithmetic is modulo 2^64.
  - The accumulate uses the {HI,LO} value present at the commit edge.
- Not defined: op codes 7-10 are undefined and treated as no-ops (busy stays 0, HI/LO unchanged).

Test Plan:
- Signed multiply: reset, then start op=1, A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA on the edge busy falls; HI/LO remain 0 during busy.
- Signed and unsigned divide: op=3, A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then op=4, same operands -> LO=0x7FFFFFFC, HI=1.
- Divide by zero: with HI=0x11, LO=0x22, issue op=3, B=0 -> busy exactly 10 cycles; HI=0x11, LO=0x22 unchanged.
- Issue during busy: during a mult (A=4, B=5), pulse start with op=5, A=0xDEAD -> ignored; final HI=0, LO=20. Then mtlo A=0xBEEF at the first non-busy edge -> LO=0xBEEF next cycle, busy stays 0.
- Reset mid-op: assert reset asynchronously (between edges) in cycle 3 of a div -> busy, HI and LO go to 0 immediately; no write occurs after reset is released.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, op=8, A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus -> busy never rises, HI/LO unchanged.
